// File: rtl/status_pkg.sv
// Shared definitions for the alarm status serial link (transmitter and receiver).
package status_pkg;
    localparam int STATUS_MSG_W = 4;

    localparam int ST_ARMED = 0;
    localparam int ST_ALARM = 1;
    localparam int ST_SENS1 = 2;
    localparam int ST_SENS2 = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_OVERRUN = 2'd2
    } rx_state_e;
endpackage

// File: rtl/link_watchdog.sv
// Saturating cycle counter; timeout is high once TIMEOUT_CYC cycles pass without clr.
module link_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    output logic timeout
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (cnt != TW'(TIMEOUT_CYC))
            cnt <= cnt + TW'(1);
    end

    assign timeout = (cnt == TW'(TIMEOUT_CYC));
endmodule

// File: rtl/status_serial_rx.sv
// Receiver for the LSB-first alarm status frame framed by STATUS_SEND.
// Optional link-loss watchdog enabled by defining STATUS_RX_LINK_TIMEOUT_EN.
module status_serial_rx
    import status_pkg::*;
#(
    parameter int MSG_W = STATUS_MSG_W
`ifdef STATUS_RX_LINK_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             STATUS_SEND,
    input  logic             STATUS_IN,
    output logic [MSG_W-1:0] STATUS,
    output logic             FRAME_VALID,
    output logic             FRAME_ERR,
    output logic             STATUS_CHG,
    output logic             LINK_OK
);
    localparam int CW = $clog2(MSG_W + 1);

    rx_state_e        state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [MSG_W-1:0] shreg, shreg_nxt;
    logic             valid_nxt, err_nxt;
    logic             to_evt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (STATUS_SEND) begin
                    shreg_nxt    = '0;
                    shreg_nxt[0] = STATUS_IN;
                    cnt_nxt      = CW'(1);
                    state_nxt    = S_RECV;
                end
            end
            S_RECV: begin
                if (STATUS_SEND) begin
                    if (cnt < CW'(MSG_W)) begin
                        for (int i = 0; i < MSG_W; i++)
                            if (CW'(i) == cnt) shreg_nxt[i] = STATUS_IN;
                        cnt_nxt = cnt + CW'(1);
                    end else begin
                        state_nxt = S_OVERRUN;
                    end
                end else begin
                    if (cnt == CW'(MSG_W)) valid_nxt = 1'b1;
                    else                   err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            S_OVERRUN: begin
                if (!STATUS_SEND) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef STATUS_RX_LINK_TIMEOUT_EN
    logic timeout;

    link_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clr     (FRAME_VALID),
        .timeout (timeout)
    );

    // Fires once: LINK_OK drops on the same edge, so the saturated count cannot retrigger.
    assign to_evt = timeout && LINK_OK && !valid_nxt;
`else
    assign to_evt = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            STATUS      <= '0;
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
            STATUS_CHG  <= 1'b0;
            LINK_OK     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            shreg       <= shreg_nxt;
            FRAME_VALID <= valid_nxt;
            FRAME_ERR   <= err_nxt | to_evt;
            STATUS_CHG  <= valid_nxt && (shreg != STATUS);
            if (valid_nxt) begin
                STATUS  <= shreg;
                LINK_OK <= 1'b1;
            end else if (to_evt) begin
                STATUS  <= '0;
                LINK_OK <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_status_serial_rx.sv
// Scoreboard bench for status_serial_rx (default build, watchdog disabled).
module tb_status_serial_rx;
    localparam int MSG_W = 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             STATUS_SEND = 1'b0;
    logic             STATUS_IN = 1'b0;
    logic [MSG_W-1:0] STATUS;
    logic             FRAME_VALID, FRAME_ERR, STATUS_CHG, LINK_OK;

    typedef struct {
        logic             is_err;
        logic [MSG_W-1:0] status;
        logic             chg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    status_serial_rx #(.MSG_W(MSG_W)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .STATUS_SEND (STATUS_SEND),
        .STATUS_IN   (STATUS_IN),
        .STATUS      (STATUS),
        .FRAME_VALID (FRAME_VALID),
        .FRAME_ERR   (FRAME_ERR),
        .STATUS_CHG  (STATUS_CHG),
        .LINK_OK     (LINK_OK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic is_err, input logic [MSG_W-1:0] st, input logic chg);
        exp_t e;
        e.is_err = is_err;
        e.status = st;
        e.chg    = chg;
        exp_q.push_back(e);
    endtask

    // len data cycles of SEND high carrying data (LSB first), then idle low cycles.
    task automatic send(input logic [7:0] data, input int len, input int idle);
        for (int i = 0; i < len; i++) begin
            STATUS_SEND = 1'b1;
            STATUS_IN   = data[i % 8];
            tick();
        end
        STATUS_SEND = 1'b0;
        STATUS_IN   = 1'b0;
        for (int i = 0; i < idle; i++) tick();
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (mon_en && (FRAME_VALID || FRAME_ERR)) begin
            exp_t e;
            checks++;
            if (FRAME_VALID && FRAME_ERR) begin
                failures++;
                $display("FAIL both_pulses: valid=%0b err=%0b expected one", FRAME_VALID, FRAME_ERR);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b status=%0h", FRAME_VALID, FRAME_ERR, STATUS);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_err", 32'(FRAME_ERR), 32'(e.is_err));
                check("pulse_status", 32'(STATUS), 32'(e.status));
                check("pulse_chg", 32'(STATUS_CHG), 32'(e.chg));
            end
        end
        if (mon_en && STATUS_CHG && !FRAME_VALID) begin
            checks++;
            failures++;
            $display("FAIL chg_without_valid: chg=%0b valid=%0b", STATUS_CHG, FRAME_VALID);
        end
    end

    initial begin
        #3;
        check("rst_status", 32'(STATUS), 32'h0);
        check("rst_valid", 32'(FRAME_VALID), 32'h0);
        check("rst_err", 32'(FRAME_ERR), 32'h0);
        check("rst_chg", 32'(STATUS_CHG), 32'h0);
        check("rst_link", 32'(LINK_OK), 32'h0);
        tick();
        RST_N = 1'b1;
        mon_en = 1'b1;
        tick();

        // First frame: pulse one cycle after SEND low is sampled
        push(1'b0, 4'b1011, 1'b1);
        send(8'b1011, 4, 0);
        tick();
        check("latency_valid", 32'(FRAME_VALID), 32'h1);
        check("first_status", 32'(STATUS), 32'hb);
        tick();
        tick();
        check("link_after_first", 32'(LINK_OK), 32'h1);

        push(1'b0, 4'b1011, 1'b0);
        send(8'b1011, 4, 3);

        push(1'b1, 4'b1011, 1'b0);
        send(8'b0101, 3, 3);
        check("short_status_kept", 32'(STATUS), 32'hb);

        push(1'b1, 4'b1011, 1'b0);
        send(8'b0011_1111, 6, 4);
        check("overrun_status_kept", 32'(STATUS), 32'hb);

        // Reset after two bits of 0110
        STATUS_SEND = 1'b1; STATUS_IN = 1'b0; tick();
        STATUS_IN = 1'b1; tick();
        RST_N = 1'b0;
        #1;
        check("midrst_status", 32'(STATUS), 32'h0);
        check("midrst_valid", 32'(FRAME_VALID), 32'h0);
        check("midrst_err", 32'(FRAME_ERR), 32'h0);
        check("midrst_chg", 32'(STATUS_CHG), 32'h0);
        check("midrst_link", 32'(LINK_OK), 32'h0);
        STATUS_SEND = 1'b0; STATUS_IN = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        tick();

        push(1'b0, 4'b0001, 1'b1);
        send(8'b0001, 4, 3);
        check("post_rst_status", 32'(STATUS), 32'h1);
        check("post_rst_link", 32'(LINK_OK), 32'h1);

        // Back-to-back with a single idle cycle
        push(1'b0, 4'b0001, 1'b0);
        push(1'b0, 4'b0011, 1'b1);
        send(8'b0001, 4, 1);
        send(8'b0011, 4, 4);
        check("b2b_status", 32'(STATUS), 32'h3);
        check("link_held", 32'(LINK_OK), 32'h1);

        for (int i = 0; i < 4; i++) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "time limit");
    end
endmodule
